// File: rtl/ps2_tx_if.sv
// Host-side command handshake of the PS/2 transmitter: byte + start strobe in,
// busy level and done/err completion pulses out.
interface ps2_tx_if;
   logic [7:0] tx_data;
   logic       tx_start;
   logic       busy;
   logic       done;
   logic       err;

   modport master (output tx_data, tx_start, input busy, done, err);
   modport slave  (input tx_data, tx_start, output busy, done, err);
endinterface

// File: rtl/ps2_tx.sv
// PS/2 host-to-device byte transmitter: inhibit, request-to-send, shift 8 data
// bits + odd parity + stop on device clock edges, then check the device ACK.
module ps2_tx #(
   parameter int INHIBIT_CYC = 2500,
   parameter int REQ_CYC     = 25,
   parameter int TIMEOUT_CYC = 375000
) (
   input  logic   clk,
   input  logic   rst,
   input  logic   ps2_c_in,
   input  logic   ps2_d_in,
   output logic   ps2_c_oe,
   output logic   ps2_d_oe,
   ps2_tx_if.slave host
);

   localparam int CMAX = (INHIBIT_CYC > REQ_CYC) ? INHIBIT_CYC : REQ_CYC;
   localparam int CW   = $clog2(CMAX + 1);
   localparam int TW   = $clog2(TIMEOUT_CYC + 1);

   typedef enum logic [2:0] {
      IDLE, INHIBIT, REQ, SHIFT, ACK, WAIT_IDLE
   } state_t;

   state_t        state, nxt;
   logic          c_s1, c_s2, c_prev, d_s1, d_s2;
   logic [CW-1:0] cnt;
   logic [TW-1:0] tcnt;
   logic [3:0]    bitcnt;
   logic [7:0]    shreg;
   logic          par;
   logic          fall, timeout, inh_end, req_end;

   assign fall    = c_prev & ~c_s2;
   assign inh_end = (cnt == CW'(INHIBIT_CYC - 1));
   assign req_end = (cnt == CW'(REQ_CYC - 1));
   assign timeout = ((state == SHIFT) || (state == ACK) || (state == WAIT_IDLE)) &&
                    (tcnt == TW'(TIMEOUT_CYC));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= nxt;
   end

   always_comb begin
      nxt = state;
      case (state)
         IDLE:      if (host.tx_start) nxt = INHIBIT;
         INHIBIT:   if (inh_end) nxt = REQ;
         REQ:       if (req_end) nxt = SHIFT;
         SHIFT: begin
            if (timeout)              nxt = IDLE;
            else if (bitcnt == 4'd10) nxt = ACK;
         end
         ACK: begin
            if (timeout)   nxt = IDLE;
            else if (fall) nxt = d_s2 ? IDLE : WAIT_IDLE;
         end
         WAIT_IDLE: begin
            if (timeout)          nxt = IDLE;
            else if (c_s2 & d_s2) nxt = IDLE;
         end
         default:   nxt = IDLE;
      endcase
   end

   always_comb begin
      ps2_c_oe  = 1'b0;
      ps2_d_oe  = 1'b0;
      host.busy = (state != IDLE);
      host.done = 1'b0;
      host.err  = timeout;
      case (state)
         INHIBIT: ps2_c_oe = 1'b1;
         REQ: begin
            ps2_c_oe = 1'b1;
            ps2_d_oe = 1'b1;
         end
         SHIFT: begin
            // Timeout wins over the bit being driven so both lines are free on exit.
            if (!timeout) begin
               if (bitcnt == 4'd0)                         ps2_d_oe = 1'b1;
               else if (bitcnt <= 4'd8)                    ps2_d_oe = ~shreg[3'(bitcnt - 4'd1)];
               else if (bitcnt == 4'd9)                    ps2_d_oe = ~par;
               else                                        ps2_d_oe = 1'b0;
            end
         end
         ACK:       if (!timeout && fall && d_s2) host.err = 1'b1;
         WAIT_IDLE: if (!timeout && c_s2 && d_s2) host.done = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         c_s1   <= 1'b1;
         c_s2   <= 1'b1;
         c_prev <= 1'b1;
         d_s1   <= 1'b1;
         d_s2   <= 1'b1;
         cnt    <= '0;
         tcnt   <= '0;
         bitcnt <= '0;
         shreg  <= '0;
         par    <= 1'b0;
      end else begin
         c_s1   <= ps2_c_in;
         c_s2   <= c_s1;
         c_prev <= c_s2;
         d_s1   <= ps2_d_in;
         d_s2   <= d_s1;
         case (state)
            IDLE: begin
               cnt <= '0;
               if (host.tx_start) begin
                  shreg <= host.tx_data;
                  par   <= ~^host.tx_data;
               end
            end
            INHIBIT: cnt <= inh_end ? '0 : cnt + CW'(1);
            REQ: begin
               if (req_end) begin
                  cnt    <= '0;
                  tcnt   <= '0;
                  bitcnt <= '0;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            SHIFT: begin
               tcnt <= tcnt + TW'(1);
               if (fall && bitcnt != 4'd10) bitcnt <= bitcnt + 4'd1;
            end
            ACK, WAIT_IDLE: tcnt <= tcnt + TW'(1);
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_ps2_tx.sv
// Directed bench for ps2_tx: a PS/2 device model clocks frames out of the DUT and
// compares them against a scoreboard of frames expected from each requested byte.
module tb_ps2_tx;
   localparam int INH = 50;
   localparam int RQ  = 5;
   localparam int TO  = 3000;
   localparam int H   = 40;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic dev_c = 1'b1;
   logic dev_d = 1'b1;
   logic ps2_c_in, ps2_d_in, ps2_c_oe, ps2_d_oe;
   assign ps2_c_in = dev_c & ~ps2_c_oe;
   assign ps2_d_in = dev_d & ~ps2_d_oe;

   ps2_tx_if bus ();

   ps2_tx #(.INHIBIT_CYC(INH), .REQ_CYC(RQ), .TIMEOUT_CYC(TO)) dut (
      .clk      (clk),
      .rst      (rst),
      .ps2_c_in (ps2_c_in),
      .ps2_d_in (ps2_d_in),
      .ps2_c_oe (ps2_c_oe),
      .ps2_d_oe (ps2_d_oe),
      .host     (bus)
   );

   int errors = 0;
   int checks = 0;
   int done_cnt = 0, err_cnt = 0, both_cnt = 0, inh_cnt = 0, req_cnt = 0;
   logic [10:0] exp_q[$];

   always @(posedge clk) begin
      #1;
      if (bus.done) done_cnt++;
      if (bus.err) err_cnt++;
      if (bus.done && bus.err) both_cnt++;
      if (ps2_c_oe && !ps2_d_oe) inh_cnt++;
      if (ps2_c_oe && ps2_d_oe) req_cnt++;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic send(input logic [7:0] d);
      @(negedge clk);
      bus.tx_data  = d;
      bus.tx_start = 1'b1;
      @(negedge clk);
      bus.tx_start = 1'b0;
   endtask

   // Device side: wait for request-to-send, clock 10 bits, then the ACK clock.
   task automatic device(input logic ack, input int inj, input int rbit,
                         output logic [10:0] fr, output logic aborted);
      int n;
      fr      = '0;
      aborted = 1'b0;
      n       = 0;
      while (!(ps2_c_oe === 1'b0 && ps2_d_oe === 1'b1) && n < 1000) begin
         @(negedge clk);
         n++;
      end
      check("rts_seen", 32'(n < 1000), 32'd1);
      repeat (H) @(negedge clk);
      fr[0] = ps2_d_in;
      for (int i = 1; i <= 10; i++) begin
         dev_c = 1'b0;
         repeat (H) @(negedge clk);
         dev_c = 1'b1;
         fr[i] = ps2_d_in;
         if (i == inj) begin
            bus.tx_data  = 8'hAA;
            bus.tx_start = 1'b1;
            @(negedge clk);
            bus.tx_start = 1'b0;
         end
         if (i == rbit) begin
            rst = 1'b1;
            #1;
            check("rst_c_oe", 32'(ps2_c_oe), 32'd0);
            check("rst_d_oe", 32'(ps2_d_oe), 32'd0);
            check("rst_busy", 32'(bus.busy), 32'd0);
            @(negedge clk);
            @(negedge clk);
            rst     = 1'b0;
            aborted = 1'b1;
            return;
         end
         repeat (H) @(negedge clk);
      end
      dev_d = ack ? 1'b0 : 1'b1;
      repeat (4) @(negedge clk);
      dev_c = 1'b0;
      repeat (H) @(negedge clk);
      dev_c = 1'b1;
      repeat (H / 2) @(negedge clk);
      dev_d = 1'b1;
   endtask

   task automatic xfer(input string tag, input logic [7:0] d, input logic ack,
                       input int inj, input int rbit, input int exp_done, input int exp_err);
      int d0, e0, i0, r0, n;
      logic [10:0] fr, expf;
      logic aborted;
      d0 = done_cnt; e0 = err_cnt; i0 = inh_cnt; r0 = req_cnt;
      exp_q.push_back({1'b1, ~^d, d, 1'b0});
      send(d);
      check({tag, "_busy_rise"}, 32'(bus.busy), 32'd1);
      device(ack, inj, rbit, fr, aborted);
      if (aborted) begin
         void'(exp_q.pop_front());
         repeat (10) @(negedge clk);
         check({tag, "_abort_done"}, 32'(done_cnt - d0), 32'd0);
         check({tag, "_abort_err"}, 32'(err_cnt - e0), 32'd0);
         check({tag, "_abort_busy"}, 32'(bus.busy), 32'd0);
         return;
      end
      n = 0;
      while ((done_cnt + err_cnt) == (d0 + e0) && n < 3000) begin
         @(negedge clk);
         n++;
      end
      check({tag, "_end_seen"}, 32'(n < 3000), 32'd1);
      expf = exp_q.pop_front();
      check({tag, "_frame"}, 32'(fr), 32'(expf));
      check({tag, "_done"}, 32'(done_cnt - d0), 32'(exp_done));
      check({tag, "_err"}, 32'(err_cnt - e0), 32'(exp_err));
      check({tag, "_inhibit_len"}, 32'(inh_cnt - i0), 32'(INH));
      check({tag, "_req_len"}, 32'(req_cnt - r0), 32'(RQ));
   endtask

   initial begin
      int n, d0, e0;
      bus.tx_data  = 8'h00;
      bus.tx_start = 1'b0;
      repeat (3) @(negedge clk);
      check("reset_c_oe", 32'(ps2_c_oe), 32'd0);
      check("reset_d_oe", 32'(ps2_d_oe), 32'd0);
      check("reset_busy", 32'(bus.busy), 32'd0);
      check("reset_done", 32'(bus.done), 32'd0);
      check("reset_err", 32'(bus.err), 32'd0);
      rst = 1'b0;
      @(negedge clk);
      check("idle_busy", 32'(bus.busy), 32'd0);

      xfer("ed", 8'hED, 1'b1, -1, -1, 1, 0);
      xfer("01", 8'h01, 1'b1, -1, -1, 1, 0);
      xfer("ff", 8'hFF, 1'b1, -1, -1, 1, 0);
      xfer("ed_inj", 8'hED, 1'b1, 3, -1, 1, 0);
      repeat (30) @(negedge clk);
      check("inj_no_second", 32'(bus.busy), 32'd0);
      xfer("nack", 8'h5A, 1'b0, -1, -1, 0, 1);

      // Device never clocks: measure clock release to err pulse.
      d0 = done_cnt; e0 = err_cnt;
      send(8'h3C);
      n = 0;
      while (ps2_c_oe !== 1'b0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      check("to_release_seen", 32'(n < 200), 32'd1);
      n = 0;
      while (bus.err !== 1'b1 && n < TO + 100) begin
         @(negedge clk);
         n++;
      end
      check("to_latency", 32'(n), 32'(TO));
      check("to_c_oe", 32'(ps2_c_oe), 32'd0);
      check("to_d_oe", 32'(ps2_d_oe), 32'd0);
      @(negedge clk);
      check("to_busy", 32'(bus.busy), 32'd0);
      check("to_err_cnt", 32'(err_cnt - e0), 32'd1);
      check("to_done_cnt", 32'(done_cnt - d0), 32'd0);

      xfer("rst_mid", 8'hED, 1'b1, -1, 4, 0, 0);
      xfer("f4", 8'hF4, 1'b1, -1, -1, 1, 0);

      check("never_both", 32'(both_cnt), 32'd0);
      check("queue_empty", 32'(exp_q.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/ps2_tx.md
PS2_TX -- requirements
Module: ps2_tx

Interface
REQ-001 Parameter INHIBIT_CYC, default 2500, is the number of clk cycles the host holds PS/2 clock low before a request (100 us at 25 MHz).
REQ-002 Parameter REQ_CYC, default 25, is the number of clk cycles data and clock are both held low before clock is released.
REQ-003 Parameter TIMEOUT_CYC, default 375000, is the maximum number of clk cycles from clock release to acknowledge (15 ms).
REQ-004 The clock and reset SHALL be a single clock and an asynchronous, active-high reset.
REQ-005 The clock port is clk (input, 1 bit): 25 MHz system clock, all logic on its rising edge.
REQ-006 The reset port is rst (input, 1 bit): asynchronous, active-high reset.
REQ-007 ps2_c_in (input, 1 bit) is the raw PS/2 clock pad level.
REQ-008 ps2_d_in (input, 1 bit) is the raw PS/2 data pad level.
REQ-009 tx_data (input, 8 bits) is the command byte to send to the keyboard.
REQ-010 tx_start (input, 1 bit) is a one-cycle request to send tx_data.
REQ-011 ps2_c_oe (output, 1 bit): 1 drives the PS/2 clock low, 0 releases it (open-drain at top level).
REQ-012 ps2_d_oe (output, 1 bit): 1 drives the PS/2 data low, 0 releases it.
REQ-013 busy (output, 1 bit) is high whenever the FSM is not IDLE.
REQ-014 done (output, 1 bit) is a one-cycle pulse when the device acknowledges.
REQ-015 err (output, 1 bit) is a one-cycle pulse on timeout or a missing ACK.

Function
REQ-016 ps2_c_in and ps2_d_in SHALL each pass through a 2-FF synchronizer; a PS/2 falling edge is when the previous synchronized clock is 1 and the current one is 0.
REQ-017 The FSM states SHALL be IDLE, INHIBIT, REQ, SHIFT, ACK, WAIT_IDLE.
REQ-018 In IDLE, tx_start=1 SHALL latch tx_data and odd parity (~^tx_data) and enter INHIBIT on the next cycle; busy rises in that same cycle.
REQ-019 tx_start while busy=1 SHALL be ignored; the latched byte is unchanged.
REQ-020 INHIBIT: ps2_c_oe=1, ps2_d_oe=0 for exactly INHIBIT_CYC cycles, then go to REQ.
REQ-021 REQ: ps2_c_oe=1, ps2_d_oe=1 (start bit) for exactly REQ_CYC cycles, then go to SHIFT with ps2_c_oe=0 and the timeout counter cleared.
REQ-022 SHIFT: the 4-bit bit counter starts at 0; on each PS/2 falling edge the counter increments.
REQ-023 SHIFT output: ps2_d_oe = ~bit, where bit is D0..D7 (LSB first) for counts 1..8 and parity for count 9; at count 10 ps2_d_oe=0 (stop bit); then go to ACK.
REQ-024 Before the first falling edge in SHIFT, ps2_d_oe SHALL remain 1 (start bit held).
REQ-025 ACK: on the next PS/2 falling edge, sample synchronized data; 0 means go to WAIT_IDLE, 1 means pulse err and go to IDLE.
REQ-026 WAIT_IDLE: when synchronized clock=1 and data=1, pulse done and go to IDLE.
REQ-027 The timeout counter runs in SHIFT, ACK and WAIT_IDLE; reaching TIMEOUT_CYC SHALL release both lines, pulse err and go to IDLE.
REQ-028 A timeout and an ACK event in the same cycle SHALL resolve as timeout.
REQ-029 done and err SHALL never both be 1; each is high for exactly one cycle, coincident with the return to IDLE (busy=0 on the following cycle).
REQ-030 In IDLE, ACK and WAIT_IDLE, ps2_c_oe=0 and ps2_d_oe=0.
REQ-031 A new tx_start is accepted in the cycle after done or err.

Reset
REQ-032 rst=1 SHALL immediately (asynchronously) force IDLE with ps2_c_oe=0, ps2_d_oe=0, busy=0, done=0, err=0, counters=0, latched byte=0x00 and synchronizers=1.
REQ-033 Reset asserted mid-transfer SHALL abort with no done or err pulse.

Verification
REQ-034 Send 0xED, with the device model clocking at 12.5 kHz and giving ACK -> clock low 2500 cycles; data low after it; sampled bits 0,1,0,1,1,0,1,1,1, parity 1, stop 1; one done pulse; no err.
REQ-035 Send 0x01 -> parity 0 sampled; send 0xFF -> parity 1; both complete with done.
REQ-036 Device never clocks -> err pulse exactly 375000 cycles after clock release; lines released; busy=0.
REQ-037 Device leaves data high at the ACK edge -> err pulse, no done.
REQ-038 tx_start=1 with 0xAA during the SHIFT of 0xED -> 0xED transmitted unchanged, a single done pulse.
REQ-039 rst pulsed during bit 4 -> ps2_c_oe=ps2_d_oe=0 within the reset pulse; no done/err; a new 0xF4 send after reset succeeds.
